counter_sequencer: RTL and testbench

Run-control sequencer for the lab's 4-bit counter display. It replaces ripple-clocked counting with a single-clock design. An internal prescaler produces an advance enable, and an FSM turns button-style commands (start, pause, single step, clear, load) into counter advances. Terminal-count detection, auto-reload and a done pulse are included. It sits between the board buttons/switches and the LEDs, in the slot the free-running counter occupies today.

---
 rtl/counter_pkg.sv | 34 +++
 rtl/tick_gen.sv | 25 ++
 rtl/counter_sequencer.sv | 115 +++++++++++
 tb/tb_counter_sequencer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types for the counter run-control sequencer: state codes, count width
// and the command bundle with its priority resolver.
package counter_pkg;

  localparam int COUNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic clear;
    logic load;
    logic start;
    logic pause;
    logic step;
  } cmd_t;

  // Only the highest-priority rising edge acts; the rest are dropped that cycle.
  function automatic cmd_t cmd_prio(input cmd_t r);
    cmd_t o;
    o = '0;
    if (r.clear)      o.clear = 1'b1;
    else if (r.load)  o.load  = 1'b1;
    else if (r.start) o.start = 1'b1;
    else if (r.pause) o.pause = 1'b1;
    else if (r.step)  o.step  = 1'b1;
    return o;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts enabled cycles and pulses adv on the last of every DIV.
// The count is held while disabled so a paused run resumes mid-period.
module tick_gen #(
  parameter int DIV   = 25_000_000,
  parameter int DIV_W = 25
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic adv
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] presc_q;

  assign adv = enable && (presc_q == LAST);

  always_ff @(posedge clock) begin
    if (!reset_n || clear) presc_q <= '0;
    else if (enable)       presc_q <= adv ? '0 : presc_q + 1'b1;
  end

endmodule

// File: rtl/counter_sequencer.sv
// Run-control sequencer for the 4-bit display counter: command edge detection,
// run/pause/step/load FSM, terminal detection with optional auto-reload.
module counter_sequencer
  import counter_pkg::*;
#(
  parameter int DIV   = 25_000_000,
  parameter int DIV_W = 25
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               pause,
  input  logic               step,
  input  logic               clear,
  input  logic               load_en,
  input  logic [COUNT_W-1:0] load_val,
  input  logic [COUNT_W-1:0] term_val,
  input  logic               dir,
  input  logic               auto_reload,
  output logic [COUNT_W-1:0] count,
  output logic               tick,
  output logic               done,
  output logic               busy,
  output logic [1:0]         state
);

  cmd_t cmd_in, cmd_q, cmd;

  state_e             state_q, state_n;
  logic [COUNT_W-1:0] count_q, count_n, nxt_val;
  logic               tick_q, done_q;
  logic               presc_en, presc_clr, adv, step_adv;

  assign cmd_in = {clear, load_en, start, pause, step};

  // Previous samples reset high so a command held through reset never fires.
  always_ff @(posedge clock) begin
    if (!reset_n) cmd_q <= '1;
    else          cmd_q <= cmd_in;
  end

  assign cmd = cmd_prio(cmd_t'(cmd_in & ~cmd_q));

  // Load/start/step are no-ops in RUN, so only clear or pause stall the prescaler.
  assign presc_en  = (state_q == RUN) && !cmd.clear && !cmd.pause;
  assign presc_clr = cmd.clear || (cmd.start && state_q == DONE);

  tick_gen #(.DIV(DIV), .DIV_W(DIV_W)) u_tick_gen (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (presc_en),
    .clear   (presc_clr),
    .adv     (adv)
  );

  always_comb begin
    if (count_q == term_val && auto_reload) nxt_val = load_val;
    else if (dir)                           nxt_val = count_q + 1'b1;
    else                                    nxt_val = count_q - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      count_q <= count_n;
      tick_q  <= adv || step_adv;
      done_q  <= (adv || step_adv) && (nxt_val == term_val);
    end
  end

  always_comb begin
    state_n  = state_q;
    count_n  = count_q;
    step_adv = 1'b0;
    if (cmd.clear) begin
      state_n = IDLE;
      count_n = '0;
    end else if (cmd.load) begin
      if (state_q != RUN)  count_n = load_val;
      if (state_q == DONE) state_n = IDLE;
    end else if (cmd.start) begin
      case (state_q)
        IDLE, PAUSE: state_n = RUN;
        DONE: begin
          state_n = RUN;
          count_n = load_val;
        end
        default: ;
      endcase
    end else if (cmd.pause) begin
      if (state_q == RUN) state_n = PAUSE;
    end else if (cmd.step) begin
      step_adv = (state_q == IDLE) || (state_q == PAUSE);
    end
    if (adv || step_adv) begin
      count_n = nxt_val;
      if (nxt_val == term_val && !auto_reload) state_n = DONE;
    end
  end

  always_comb begin
    busy  = (state_q == RUN);
    state = state_q;
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign done  = done_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Randomized bench for counter_sequencer against a rule-level reference model.
module tb_counter_sequencer;

  localparam int DIV = 4;

  logic       clock = 1'b0, reset_n = 1'b0;
  logic       start = 1'b0, pause = 1'b0, step = 1'b0, clear = 1'b0, load_en = 1'b0;
  logic [3:0] load_val = 4'd0, term_val = 4'd0;
  logic       dir = 1'b1, auto_reload = 1'b0;
  logic [3:0] count;
  logic       tick, done, busy;
  logic [1:0] state;

  counter_sequencer #(.DIV(DIV), .DIV_W(4)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .pause(pause), .step(step),
    .clear(clear), .load_en(load_en), .load_val(load_val), .term_val(term_val),
    .dir(dir), .auto_reload(auto_reload), .count(count), .tick(tick), .done(done),
    .busy(busy), .state(state)
  );

  always #5 clock = ~clock;

  int n_vec = 0, n_bad = 0;

  // Reference: 0 idle, 1 run, 2 pause, 3 done; m_phase = run cycles since last advance.
  int       m_state = 0, m_count = 0, m_phase = 0;
  bit       m_tick = 0, m_done = 0;
  bit [4:0] m_prev = '1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_step();
    bit [4:0] now, rise;
    bit       adv;
    int       st0, nc;
    now    = {clear, load_en, start, pause, step};
    m_tick = 0;
    m_done = 0;
    if (!reset_n) begin
      m_state = 0; m_count = 0; m_phase = 0; m_prev = '1;
      return;
    end
    rise   = now & ~m_prev;
    m_prev = now;
    adv    = 0;
    st0    = m_state;
    if (rise[4]) begin
      m_state = 0; m_count = 0; m_phase = 0;
    end else if (rise[3]) begin
      if (st0 != 1) m_count = load_val;
      if (st0 == 3) m_state = 0;
    end else if (rise[2]) begin
      if (st0 == 0 || st0 == 2) m_state = 1;
      else if (st0 == 3) begin m_state = 1; m_count = load_val; m_phase = 0; end
    end else if (rise[1]) begin
      if (st0 == 1) m_state = 2;
    end else if (rise[0]) begin
      if (st0 == 0 || st0 == 2) adv = 1;
    end
    // Time passes in RUN unless this cycle's command stopped the run.
    if (st0 == 1 && m_state == 1) begin
      m_phase++;
      if (m_phase == DIV) begin m_phase = 0; adv = 1; end
    end
    if (adv) begin
      if (m_count == term_val && auto_reload) nc = load_val;
      else nc = (m_count + (dir ? 1 : 15)) % 16;
      m_count = nc;
      m_tick  = 1;
      if (nc == term_val) begin
        m_done = 1;
        if (!auto_reload) m_state = 3;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
    chk("count", count, m_count);
    chk("tick",  tick,  m_tick);
    chk("done",  done,  m_done);
    chk("busy",  busy,  m_state == 1);
    chk("state", state, m_state);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    // start held through reset release must not run
    reset_n = 1'b0; start = 1'b1;
    cycles(2);
    reset_n = 1'b1;
    cycles(3);
    start = 1'b0;
    cycles(1);

    // count up to terminal 5 and stop in DONE
    term_val = 4'd5; dir = 1'b1; auto_reload = 1'b0;
    start = 1'b1; cycles(1); start = 1'b0;
    cycles(26);

    // load 2, count down through the 0->15 wrap to 14
    load_val = 4'd2; term_val = 4'd14; dir = 1'b0;
    load_en = 1'b1; cycles(1); load_en = 1'b0;
    start = 1'b1; cycles(1); start = 1'b0;
    cycles(20);

    // auto-reload 3..6 while running, then pause, step, resume
    clear = 1'b1; cycles(1); clear = 1'b0;
    load_val = 4'd3; term_val = 4'd6; dir = 1'b1; auto_reload = 1'b1;
    load_en = 1'b1; cycles(1); load_en = 1'b0;
    start = 1'b1; cycles(1); start = 1'b0;
    cycles(30);
    pause = 1'b1; cycles(1); pause = 1'b0;
    cycles(5);
    step = 1'b1; cycles(1); step = 1'b0;
    start = 1'b1; cycles(1); start = 1'b0;
    cycles(10);

    // coincident clear, load and start; then reset while running
    clear = 1'b1; load_en = 1'b1; start = 1'b1; cycles(1);
    clear = 1'b0; load_en = 1'b0; start = 1'b0; cycles(1);
    start = 1'b1; cycles(1); start = 1'b0;
    cycles(9);
    reset_n = 1'b0; cycles(1); reset_n = 1'b1;
    cycles(2);

    for (int i = 0; i < 4000; i++) begin
      reset_n = ($urandom_range(0, 199) != 0);
      clear   = ($urandom_range(0, 59) == 0);
      load_en = ($urandom_range(0, 24) == 0);
      start   = ($urandom_range(0, 5) == 0);
      pause   = ($urandom_range(0, 14) == 0);
      step    = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) term_val = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0)  load_val = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) dir = ~dir;
      if ($urandom_range(0, 39) == 0) auto_reload = ~auto_reload;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
